// File: rtl/mem_port_arbiter_if.sv
// Bundles the per-core request/response signals and the shared memory port of mem_port_arbiter.
// master: the arbiter's view (drives grants/responses and the memory request).
// slave: the environment's view (the cores and the memory).
interface mem_port_arbiter_if #(
  parameter int unsigned NUM_CORES  = 8,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 64
);

  // Core side
  logic [NUM_CORES-1:0]            core_req;
  logic [NUM_CORES-1:0]            core_we;
  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr;
  logic [NUM_CORES*DATA_WIDTH-1:0] core_wdata;
  logic [NUM_CORES-1:0]            core_gnt;
  logic [NUM_CORES-1:0]            core_rvalid;
  logic [DATA_WIDTH-1:0]           core_rdata;
  logic                            core_err;

  // Memory side
  logic                  m_req;
  logic                  m_we;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic                  m_ready;
  logic                  m_rvalid;
  logic [DATA_WIDTH-1:0] m_rdata;

  modport master (
    input  core_req,
    input  core_we,
    input  core_addr,
    input  core_wdata,
    output core_gnt,
    output core_rvalid,
    output core_rdata,
    output core_err,
    output m_req,
    output m_we,
    output m_addr,
    output m_wdata,
    input  m_ready,
    input  m_rvalid,
    input  m_rdata
  );

  modport slave (
    output core_req,
    output core_we,
    output core_addr,
    output core_wdata,
    input  core_gnt,
    input  core_rvalid,
    input  core_rdata,
    input  core_err,
    input  m_req,
    input  m_we,
    input  m_addr,
    input  m_wdata,
    output m_ready,
    output m_rvalid,
    output m_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_CORES requesters, one transaction at a
// time, with a response timeout that returns an error to the owning core.
module mem_port_arbiter #(
  parameter int unsigned NUM_CORES      = 8,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned OwnerW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  mem_port_arbiter_if.master      bus_io,
  output logic                    busy_o,
  output logic [OwnerW-1:0]       owner_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] TermCnt =
      CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitResp
  } state_e;

  state_e                 state_q, state_d;
  logic [OwnerW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [OwnerW-1:0]      owner_q, owner_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [NUM_CORES-1:0]   gnt_q, gnt_d;
  logic [NUM_CORES-1:0]   rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic                   pick_valid;
  logic [OwnerW-1:0]      pick_idx;
  logic                   issue;
  logic                   timeout_hit;

  // Index base+off modulo NUM_CORES; off is always below NUM_CORES.
  function automatic logic [OwnerW-1:0] wrap_idx(input logic [OwnerW-1:0] base,
                                                 input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_CORES) begin
      sum = sum - NUM_CORES;
    end
    return sum[OwnerW-1:0];
  endfunction

  // First requester at or after rr_ptr_q, scanning with wrap-around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!pick_valid && bus_io.core_req[wrap_idx(rr_ptr_q, i)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_idx(rr_ptr_q, i);
      end
    end
  end

  assign issue       = (state_q == StIssue);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TermCnt);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          owner_d         = pick_idx;
          we_d            = bus_io.core_we[pick_idx];
          addr_d          = bus_io.core_addr[32'(pick_idx) * ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d         = bus_io.core_wdata[32'(pick_idx) * DATA_WIDTH +: DATA_WIDTH];
          rr_ptr_d        = wrap_idx(pick_idx, 1);
          gnt_d[pick_idx] = 1'b1;
          state_d         = StIssue;
        end
      end

      StIssue: begin
        if (bus_io.m_ready) begin
          cnt_d   = '0;
          state_d = StWaitResp;
        end
      end

      StWaitResp: begin
        // A response in the terminal-count cycle still wins over the timeout.
        if (bus_io.m_rvalid) begin
          rvalid_d[owner_q] = 1'b1;
          rdata_d           = we_q ? '0 : bus_io.m_rdata;
          err_d             = 1'b0;
          state_d           = StIdle;
        end else if (timeout_hit) begin
          rvalid_d[owner_q] = 1'b1;
          rdata_d           = '0;
          err_d             = 1'b1;
          state_d           = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign bus_io.core_gnt    = gnt_q;
  assign bus_io.core_rvalid = rvalid_q;
  assign bus_io.core_rdata  = rdata_q;
  assign bus_io.core_err    = err_q;

  assign bus_io.m_req   = issue;
  assign bus_io.m_we    = issue & we_q;
  assign bus_io.m_addr  = addr_q;
  assign bus_io.m_wdata = wdata_q;

  assign busy_o  = (state_q != StIdle);
  assign owner_o = owner_q;

  gnt_onehot_a : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_q));
  rvalid_onehot_a : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(rvalid_q));
  issue_stable_a : assert property (@(posedge clk_i) disable iff (rst_i)
      (issue && !bus_io.m_ready) |=> (issue && $stable(addr_q) && $stable(wdata_q)
                                      && $stable(we_q)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written corner
// sequences and a randomized phase checked against a transaction-level round-robin model.
module tb_mem_port_arbiter;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 64;
  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [2:0] owner;

  mem_port_arbiter_if #(.NUM_CORES(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_port_arbiter #(
    .NUM_CORES      (N),
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus_io  (bus),
    .busy_o  (busy),
    .owner_o (owner)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        c_we    [N];
  logic [63:0] c_addr  [N];
  logic [63:0] c_wdata [N];
  logic [63:0] last_rd;
  logic        last_err;

  typedef struct {
    logic [7:0]  req;
    logic [7:0]  exp_gnt;
    int          rdy;
    int          resp_at;
    logic [63:0] rsp;
  } vec_t;

  vec_t tbl [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_cores();
    for (int i = 0; i < N; i++) begin
      bus.core_we[i]              = c_we[i];
      bus.core_addr[i*AW +: AW]   = c_addr[i];
      bus.core_wdata[i*DW +: DW]  = c_wdata[i];
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.core_req  = '0;
    bus.m_ready   = 1'b0;
    bus.m_rvalid  = 1'b0;
    step();
    step();
    rst      = 1'b0;
    last_rd  = '0;
    last_err = 1'b0;
  endtask

  // Runs one whole transaction from an IDLE cycle; resp_at > 15 means memory never answers.
  task automatic do_txn(input logic [7:0] req, input logic [7:0] exp_gnt, input int rdy_dly,
                        input int resp_at, input logic [63:0] rsp, input bit stray,
                        input string nm);
    int          o;
    logic [63:0] exp_rd;
    logic        exp_err;
    o = 0;
    for (int i = 0; i < N; i++) if (exp_gnt[i]) o = i;
    drive_cores();
    bus.core_req = req;
    bus.m_rvalid = stray;
    bus.m_rdata  = {$urandom, $urandom};
    step();
    bus.m_rvalid = 1'b0;
    chk({nm, ".gnt"}, 64'(bus.core_gnt), 64'(exp_gnt));
    chk({nm, ".owner"}, 64'(owner), 64'(o));
    chk({nm, ".busy"}, 64'(busy), 64'd1);
    chk({nm, ".no_rvalid"}, 64'(bus.core_rvalid), 64'd0);
    chk({nm, ".rdata_hold"}, bus.core_rdata, last_rd);
    chk({nm, ".err_hold"}, 64'(bus.core_err), 64'(last_err));
    bus.core_req = req & ~exp_gnt;
    for (int k = 0; k <= rdy_dly; k++) begin
      bus.m_ready = (k == rdy_dly);
      chk({nm, ".m_req"}, 64'(bus.m_req), 64'd1);
      chk({nm, ".m_we"}, 64'(bus.m_we), 64'(c_we[o]));
      chk({nm, ".m_addr"}, bus.m_addr, c_addr[o]);
      chk({nm, ".m_wdata"}, bus.m_wdata, c_wdata[o]);
      if (k > 0) chk({nm, ".gnt_pulse"}, 64'(bus.core_gnt), 64'd0);
      step();
    end
    bus.m_ready = 1'b0;
    chk({nm, ".m_req_drop"}, 64'(bus.m_req), 64'd0);
    for (int w = 0; w < TO; w++) begin
      bus.m_rvalid = (w == resp_at);
      bus.m_rdata  = rsp;
      step();
      bus.m_rvalid = 1'b0;
      if (w == resp_at || w == TO - 1) break;
      chk({nm, ".wait_no_rvalid"}, 64'(bus.core_rvalid), 64'd0);
    end
    if (resp_at < TO) begin
      exp_rd  = c_we[o] ? 64'd0 : rsp;
      exp_err = 1'b0;
    end else begin
      exp_rd  = 64'd0;
      exp_err = 1'b1;
    end
    chk({nm, ".rvalid"}, 64'(bus.core_rvalid), 64'(exp_gnt));
    chk({nm, ".rdata"}, bus.core_rdata, exp_rd);
    chk({nm, ".err"}, 64'(bus.core_err), 64'(exp_err));
    chk({nm, ".idle"}, 64'(busy), 64'd0);
    last_rd  = exp_rd;
    last_err = exp_err;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1);
  end

  initial begin
    int          mptr;
    logic [7:0]  pending;
    logic [7:0]  newm;
    int          best;
    int          bestd;
    int          d;
    int          r;
    int          resp_at;

    tbl[0]  = '{8'h04, 8'h04, 0, 0, 64'hDEADBEEF};
    tbl[1]  = '{8'h08, 8'h08, 1, 2, 64'h1111_2222_3333_4444};
    tbl[2]  = '{8'h22, 8'h20, 0, 0, 64'h5555};
    tbl[3]  = '{8'h02, 8'h02, 2, 1, 64'h6666};
    tbl[4]  = '{8'hFF, 8'h04, 0, 3, 64'h7777};
    tbl[5]  = '{8'h03, 8'h01, 0, 0, 64'h8888};
    tbl[6]  = '{8'h81, 8'h80, 1, 0, 64'h9999};
    tbl[7]  = '{8'h81, 8'h01, 0, 1, 64'hAAAA};
    tbl[8]  = '{8'h40, 8'h40, 4, 1, 64'hBBBB};
    tbl[9]  = '{8'h41, 8'h01, 0, 0, 64'hCCCC};
    tbl[10] = '{8'h41, 8'h40, 0, 2, 64'hDDDD};

    for (int c = 0; c < N; c++) begin
      c_we[c]    = (c == 6);
      c_addr[c]  = (c == 2) ? 64'h100 : 64'h1000 * 64'(c) + 64'h40;
      c_wdata[c] = 64'hA5A5_0000_0000_0000 | 64'(c);
    end
    bus.core_req   = '0;
    bus.core_we    = '0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    bus.m_ready    = 1'b0;
    bus.m_rvalid   = 1'b0;
    bus.m_rdata    = '0;

    do_reset();
    chk("reset.gnt", 64'(bus.core_gnt), 64'd0);
    chk("reset.rvalid", 64'(bus.core_rvalid), 64'd0);
    chk("reset.rdata", bus.core_rdata, 64'd0);
    chk("reset.err", 64'(bus.core_err), 64'd0);
    chk("reset.m_req", 64'(bus.m_req), 64'd0);
    chk("reset.m_we", 64'(bus.m_we), 64'd0);
    chk("reset.m_addr", bus.m_addr, 64'd0);
    chk("reset.m_wdata", bus.m_wdata, 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.owner", 64'(owner), 64'd0);

    for (int v = 0; v < 11; v++) begin
      do_txn(tbl[v].req, tbl[v].exp_gnt, tbl[v].rdy, tbl[v].resp_at, tbl[v].rsp, 1'b0,
             $sformatf("vec%0d", v));
    end

    // All cores requesting continuously: strict 0..7,0 order.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      do_txn(8'hFF, 8'(1 << (k % 8)), 0, 0, 64'(k) + 64'h50, 1'b0, $sformatf("fair%0d", k));
    end

    // Timeout, then a late response in IDLE, then a normal transaction.
    do_txn(8'h08, 8'h08, 0, 99, 64'h1234, 1'b0, "timeout");
    bus.core_req = '0;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 64'hBAD;
    step();
    bus.m_rvalid = 1'b0;
    chk("late.rvalid", 64'(bus.core_rvalid), 64'd0);
    chk("late.busy", 64'(busy), 64'd0);
    step();
    chk("late.rvalid2", 64'(bus.core_rvalid), 64'd0);
    chk("late.rdata_hold", bus.core_rdata, 64'd0);
    chk("late.err_hold", 64'(bus.core_err), 64'd1);
    do_txn(8'h08, 8'h08, 1, 2, 64'hFACE, 1'b0, "post_timeout");
    do_txn(8'h01, 8'h01, 0, TO - 1, 64'hC0DE, 1'b0, "rvalid_at_term");

    // Reset while waiting for the response: dropped silently, pointer back to 0.
    bus.core_req = 8'h10;
    step();
    chk("rstw.gnt", 64'(bus.core_gnt), 64'h10);
    bus.core_req = '0;
    bus.m_ready  = 1'b1;
    step();
    bus.m_ready = 1'b0;
    chk("rstw.busy_wait", 64'(busy), 64'd1);
    rst          = 1'b1;
    bus.m_rvalid = 1'b1;
    step();
    rst          = 1'b0;
    bus.m_rvalid = 1'b0;
    chk("rstw.busy", 64'(busy), 64'd0);
    chk("rstw.rvalid", 64'(bus.core_rvalid), 64'd0);
    chk("rstw.rdata", bus.core_rdata, 64'd0);
    chk("rstw.err", 64'(bus.core_err), 64'd0);
    chk("rstw.m_req", 64'(bus.m_req), 64'd0);
    chk("rstw.owner", 64'(owner), 64'd0);
    last_rd  = '0;
    last_err = 1'b0;
    do_txn(8'hFF, 8'h01, 0, 0, 64'h4242, 1'b1, "rstw.first");

    // Randomized phase: pending requests persist across transactions until granted.
    mptr    = 1;
    pending = 8'hFE;
    for (int t = 0; t < 60; t++) begin
      newm = 8'($urandom_range(0, 255)) & ~pending;
      if ((pending | newm) == 8'h00) newm = 8'(1 << $urandom_range(0, 7));
      for (int c = 0; c < N; c++) begin
        if (newm[c]) begin
          c_we[c]    = 1'($urandom_range(0, 1));
          c_addr[c]  = {$urandom, $urandom};
          c_wdata[c] = {$urandom, $urandom};
        end
      end
      pending = pending | newm;
      best  = 0;
      bestd = N;
      for (int c = 0; c < N; c++) begin
        if (pending[c]) begin
          d = (c - mptr + N) % N;
          if (d < bestd) begin
            bestd = d;
            best  = c;
          end
        end
      end
      r = $urandom_range(0, 19);
      if (r < 14)      resp_at = r % 4;
      else if (r < 17) resp_at = TO - 1;
      else             resp_at = 99;
      do_txn(pending, 8'(1 << best), $urandom_range(0, 3), resp_at, {$urandom, $urandom},
             ($urandom_range(0, 7) == 0), $sformatf("rnd%0d", t));
      pending = pending & ~8'(1 << best);
      mptr    = (best + 1) % N;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter sharing one memory port among up to NUM_CORES riscv_core instances (one per core_id).
- Sits between the cores' mem_request/mem_write/mem_addr/mem_data interfaces and the shared data memory.
- Registers one transaction at a time, drives it to memory with a ready handshake, and routes the response back to the owning core.
- Recovers from an unresponsive memory with a timeout that returns an error response.

Parameters:
- NUM_CORES, 8, number of requesters (2..8); OWNER_W = $clog2(NUM_CORES).
- DATA_WIDTH, 64, data bus width.
- ADDR_WIDTH, 64, address width.
- TIMEOUT_CYCLES, 256, response wait limit in WAIT_RESP; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- core_req  in  NUM_CORES  per-core request; held until core_gnt.
- core_we  in  NUM_CORES  per-core write flag.
- core_addr  in  NUM_CORES*ADDR_WIDTH  flattened addresses; core i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- core_wdata  in  NUM_CORES*DATA_WIDTH  flattened write data, same packing.
- core_gnt  out  NUM_CORES  one-hot, one-cycle pulse: request accepted.
- core_rvalid  out  NUM_CORES  one-hot, one-cycle pulse: response for owner.
- core_rdata  out  DATA_WIDTH  response data, shared by all cores; valid with core_rvalid.
- core_err  out  1  qualifies core_rvalid: 1 = timeout.
- m_req  out  1  memory request.
- m_we  out  1  memory write.
- m_addr  out  ADDR_WIDTH  memory address.
- m_wdata  out  DATA_WIDTH  memory write data.
- m_ready  in  1  memory accepts (m_req & m_ready = transfer).
- m_rvalid  in  1  memory response for both reads and writes.
- m_rdata  in  DATA_WIDTH  read data; ignored for writes.
- busy  out  1  state != IDLE.
- owner  out  OWNER_W  current/last granted core.

Behaviour:
- Reset: all outputs 0; state IDLE; rr_ptr = 0; timeout counter 0. Reset wins over every other event, including mid-ISSUE and mid-WAIT_RESP. An in-flight transaction is dropped silently, with no rvalid.
- FSM states: IDLE, ISSUE, WAIT_RESP.
- IDLE: if any core_req is high, select the first requester at or after rr_ptr, wrapping at NUM_CORES.
  - At the edge: latch owner, we, addr, wdata; set rr_ptr = (owner+1) mod NUM_CORES; go to ISSUE.
  - core_gnt[owner] is high for exactly the first ISSUE cycle.
- ISSUE: m_req=1 with the latched m_we/m_addr/m_wdata, all stable until m_req & m_ready.
  - On m_req & m_ready, go to WAIT_RESP and clear the timeout counter.
  - No timeout applies in ISSUE.
- WAIT_RESP: m_req=0.
  - On m_rvalid: next cycle core_rvalid[owner]=1, core_rdata=m_rdata (0 for writes), core_err=0; go to IDLE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 with no m_rvalid: next cycle core_rvalid[owner]=1, core_err=1, core_rdata=0; go to IDLE.
- m_rvalid arriving in the same cycle as the timeout terminal count: the response wins (err=0).
- m_rvalid outside WAIT_RESP (stray or late after a timeout) is ignored and causes no output.
- core_rdata and core_err hold their values until the next core_rvalid.
- Minimum latency is 3 cycles from sampled request to core_rvalid: gnt at +1, m_ready at +1, m_rvalid at +2, core_rvalid at +3.
- Only one transaction is outstanding at a time. Requests seen during ISSUE/WAIT_RESP wait; core_req is sampled only in IDLE.
- A core must deassert or re-present core_req after core_gnt. A request still high when IDLE is re-entered is treated as a new transaction.
- Indices >= NUM_CORES never occur. rr_ptr wraps NUM_CORES-1 -> 0.
- Fairness: with all cores requesting continuously, each core is granted exactly once per NUM_CORES grants.

Test Plan:
- Single read, core 2, addr 0x100: m_ready at gnt cycle, m_rvalid with 0xDEADBEEF one cycle later -> core_gnt=0x04, then core_rvalid=0x04 with core_rdata=0xDEADBEEF, err=0, 3 cycles after the request.
- All 8 cores request continuously -> grant order 0,1,2,...,7,0; owner tracks each; no core is granted twice within 8 grants.
- Grant core 3, then requests on cores 1 and 5 together -> core 5 is granted before core 1 (rr_ptr=4).
- Write from core 6 with m_ready low for 4 cycles -> m_req, m_we=1, m_addr, m_wdata stable for all 5 ISSUE cycles; single transfer; core_rvalid=0x40 after m_rvalid.
- TIMEOUT_CYCLES=16, no m_rvalid -> core_rvalid[owner] with err=1 and rdata=0 on the 17th cycle after the transfer. A late m_rvalid in IDLE produces no output, and the next transaction completes normally.
- rst asserted in WAIT_RESP -> next cycle: busy=0, all outputs 0, rr_ptr=0; a following request from core 0 is granted first.
